// File: rtl/sync_elastic_fifo.sv
// Single-clock elastic FIFO with arbitrary depth, selectable registered or
// first-word-fall-through read, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a high-water-mark monitor.
module sync_elastic_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned FWFT       = 0,
   parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // write side
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  almost_full,
   // read side
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  almost_empty,
   // occupancy and thresholds
   output logic [CNT_W-1:0]      count,
   input  logic [CNT_W-1:0]      af_thresh,
   input  logic [CNT_W-1:0]      ae_thresh,
   // error and monitor
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr,
   output logic [CNT_W-1:0]      high_water,
   input  logic                  hw_clr
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [CNT_W-1:0]      count_next;

   // Pointer increment with explicit wrap so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Status flags, accept qualification and next occupancy from the count register.
   always_comb begin
      full         = (count == DEPTH_C);
      empty        = (count == '0);
      almost_full  = (count >= af_thresh);
      almost_empty = (count <= ae_thresh);
      wr_acc       = wr_en & ~full;
      rd_acc       = rd_en & ~empty;
      count_next   = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         count <= count_next;
      end
   end

   // Storage array; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & full)  overflow <= 1'b1;
         else if (err_clr)  overflow <= 1'b0;
         if (rd_en & empty) underflow <= 1'b1;
         else if (err_clr)  underflow <= 1'b0;
      end
   end

   // High-water mark of occupancy; clearing reloads it with the new occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_water <= '0;
      end else if (hw_clr || (count_next > high_water)) begin
         high_water <= count_next;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented directly; zero when there is nothing to show.
         always_comb begin
            rd_valid = ~empty;
            rd_data  = empty ? '0 : mem[rd_ptr];
         end
      end else begin : g_reg
         // Registered read: data appears one cycle after an accepted read.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_valid <= 1'b0;
               rd_data  <= '0;
            end else begin
               rd_valid <= rd_acc;
               if (rd_acc) rd_data <= mem[rd_ptr];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_elastic_fifo.sv
// Randomized scoreboard bench for sync_elastic_fifo: one registered-read
// instance (DEPTH=16) and one FWFT instance (DEPTH=6) driven by shared stimulus.
module tb_sync_elastic_fifo;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic       err_clr = 1'b0;
   logic       hw_clr = 1'b0;

   logic [4:0] af0 = 5'd12, ae0 = 5'd3;
   logic [2:0] af1 = 3'd4,  ae1 = 3'd1;

   logic       full0, afull0, empty0, aempty0, rv0, ov0, un0;
   logic [7:0] rd0;
   logic [4:0] cnt0, hw0;
   logic       full1, afull1, empty1, aempty1, rv1, ov1, un1;
   logic [7:0] rd1;
   logic [2:0] cnt1, hw1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_elastic_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_reg (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_data(wr_data), .full(full0), .almost_full(afull0),
      .rd_en(rd_en), .rd_data(rd0), .rd_valid(rv0), .empty(empty0),
      .almost_empty(aempty0), .count(cnt0), .af_thresh(af0), .ae_thresh(ae0),
      .overflow(ov0), .underflow(un0), .err_clr(err_clr),
      .high_water(hw0), .hw_clr(hw_clr));

   sync_elastic_fifo #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_data(wr_data), .full(full1), .almost_full(afull1),
      .rd_en(rd_en), .rd_data(rd1), .rd_valid(rv1), .empty(empty1),
      .almost_empty(aempty1), .count(cnt1), .af_thresh(af1), .ae_thresh(ae1),
      .overflow(ov1), .underflow(un1), .err_clr(err_clr),
      .high_water(hw1), .hw_clr(hw_clr));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference models: FIFO contents as queues, flags from occupancy rules.
   logic [7:0] m0_q[$], m0_sb[$], m1_q[$], m1_sb[$];
   bit m0_rv = 0, m0_ov = 0, m0_un = 0, m1_ov = 0, m1_un = 0;
   int m0_hw = 0, m1_hw = 0;
   bit wa, ra;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_q.delete(); m0_sb.delete(); m1_q.delete(); m1_sb.delete();
         m0_rv = 0; m0_ov = 0; m0_un = 0; m0_hw = 0;
         m1_ov = 0; m1_un = 0; m1_hw = 0;
      end else begin
         // registered-read model, depth 16
         wa = wr_en && (m0_q.size() < 16);
         ra = rd_en && (m0_q.size() > 0);
         if (wr_en && m0_q.size() == 16) m0_ov = 1; else if (err_clr) m0_ov = 0;
         if (rd_en && m0_q.size() == 0)  m0_un = 1; else if (err_clr) m0_un = 0;
         m0_rv = ra;
         if (ra) m0_sb.push_back(m0_q.pop_front());
         if (wa) m0_q.push_back(wr_data);
         if (hw_clr || m0_q.size() > m0_hw) m0_hw = m0_q.size();
         // FWFT model, depth 6
         wa = wr_en && (m1_q.size() < 6);
         ra = rd_en && (m1_q.size() > 0);
         if (wr_en && m1_q.size() == 6) m1_ov = 1; else if (err_clr) m1_ov = 0;
         if (rd_en && m1_q.size() == 0) m1_un = 1; else if (err_clr) m1_un = 0;
         if (ra) void'(m1_q.pop_front());
         if (wa) begin m1_q.push_back(wr_data); m1_sb.push_back(wr_data); end
         if (hw_clr || m1_q.size() > m1_hw) m1_hw = m1_q.size();
      end
   end

   // Monitor: compares every status output and pops read data as the DUT presents it.
   always @(negedge clk) begin
      chk("count0", cnt0, m0_q.size());
      chk("full0", full0, m0_q.size() == 16);
      chk("empty0", empty0, m0_q.size() == 0);
      chk("afull0", afull0, m0_q.size() >= int'(af0));
      chk("aempty0", aempty0, m0_q.size() <= int'(ae0));
      chk("ovf0", ov0, m0_ov);
      chk("unf0", un0, m0_un);
      chk("hw0", hw0, m0_hw);
      chk("rvalid0", rv0, m0_rv);
      if (rv0) begin
         if (m0_sb.size() == 0) chk("rdata0_unexpected", 1, 0);
         else chk("rdata0", rd0, m0_sb.pop_front());
      end
      chk("count1", cnt1, m1_q.size());
      chk("full1", full1, m1_q.size() == 6);
      chk("empty1", empty1, m1_q.size() == 0);
      chk("afull1", afull1, m1_q.size() >= int'(af1));
      chk("aempty1", aempty1, m1_q.size() <= int'(ae1));
      chk("ovf1", ov1, m1_ov);
      chk("unf1", un1, m1_un);
      chk("hw1", hw1, m1_hw);
      chk("rvalid1", rv1, m1_q.size() > 0);
      if (rv1) begin
         if (m1_sb.size() == 0) chk("rdata1_unexpected", 1, 0);
         else begin
            chk("rdata1", rd1, m1_sb[0]);
            if (rd_en) void'(m1_sb.pop_front());
         end
      end else begin
         chk("rdata1_zero", rd1, 0);
      end
   end

   // Drive one cycle of inputs just after the active edge.
   task automatic cyc(input bit w, input bit r, input logic [7:0] d,
                      input bit ec = 0, input bit hc = 0);
      @(posedge clk); #2;
      wr_en = w; rd_en = r; wr_data = d; err_clr = ec; hw_clr = hc;
   endtask

   task automatic check_reset_values();
      chk("rst_count0", cnt0, 0);   chk("rst_count1", cnt1, 0);
      chk("rst_full0", full0, 0);   chk("rst_empty0", empty0, 1);
      chk("rst_empty1", empty1, 1); chk("rst_rvalid0", rv0, 0);
      chk("rst_rvalid1", rv1, 0);   chk("rst_rdata0", rd0, 0);
      chk("rst_rdata1", rd1, 0);    chk("rst_ovf0", ov0, 0);
      chk("rst_unf0", un0, 0);      chk("rst_hw0", hw0, 0);
      chk("rst_hw1", hw1, 0);       chk("rst_aempty0", aempty0, 1);
      chk("rst_afull0", afull0, af0 == 5'd0);
   endtask

   task automatic random_phase(input int n);
      int pw = 50, pr = 50;
      for (int i = 0; i < n; i++) begin
         if (i % 40 == 0) begin
            pw = $urandom_range(15, 85);
            pr = $urandom_range(15, 85);
         end
         cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
             8'($urandom), $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4);
         if ($urandom_range(0, 99) < 5) begin
            af0 = 5'($urandom_range(0, 18)); ae0 = 5'($urandom_range(0, 17));
            af1 = 3'($urandom_range(0, 7));  ae1 = 3'($urandom_range(0, 7));
         end
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2 check_reset_values();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Fill past full (17 writes), then clear errors, then drain with one extra read.
      for (int i = 0; i < 17; i++) cyc(1, 0, 8'(i));
      cyc(0, 0, 8'h00, 1);
      for (int i = 0; i < 17; i++) cyc(0, 1, 8'h00);
      cyc(0, 1, 8'h00, 1);
      cyc(0, 0, 8'h00, 1);

      // Hold occupancy at 3 with simultaneous read and write.
      for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h40 + i));
      for (int i = 0; i < 10; i++) cyc(1, 1, 8'(8'h50 + i));

      // Full with simultaneous read and write: read accepted, write rejected.
      for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h80 + i));
      for (int i = 0; i < 3; i++) cyc(1, 1, 8'(8'hC0 + i));

      // Threshold change mid-fill, then drain and high-water clear.
      af0 = 5'd8; af1 = 3'd2;
      for (int i = 0; i < 12; i++) cyc(0, 1, 8'h00);
      cyc(0, 0, 8'h00, 0, 1);
      cyc(0, 0, 8'h00);

      random_phase(800);

      // Reset in the middle of a cycle while traffic is flowing.
      cyc(1, 1, 8'hA5);
      @(posedge clk); #3 rst_n = 1'b0;
      #1 check_reset_values();
      @(posedge clk); #2 rst_n = 1'b1;

      random_phase(400);
      for (int i = 0; i < 20; i++) cyc(0, 1, 8'h00);
      cyc(0, 0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      chk("sb0_drained", m0_sb.size(), 0);
      chk("sb1_drained", m1_sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
